// File: rtl/dm_store_merge_pkg.sv
// Shared store-path types and lane geometry for the M-stage data memory.
package dm_store_merge_pkg;

  localparam int LANE_W = 8;
  localparam int LANES  = 4;

  typedef enum logic [1:0] {
    ST_SW  = 2'b00,
    ST_SH  = 2'b01,
    ST_SB  = 2'b10,
    ST_RSV = 2'b11
  } store_t;

  function automatic logic [31:0] lane_mask32(input logic [3:0] be);
    logic [31:0] m;
    m = '0;
    for (int k = 0; k < LANES; k++)
      m[k*LANE_W +: LANE_W] = {LANE_W{be[k]}};
    return m;
  endfunction

endpackage

// File: rtl/dm_store_merge_lane_gen.sv
// Store lane decode: lane mask, lane-replicated source data and
// reject flag (misaligned or reserved store type).
module store_lane_gen
  import dm_store_merge_pkg::*;
(
  input  logic [1:0]  i_store_type,
  input  logic [1:0]  i_addr,
  input  logic [31:0] i_wdata,
  output logic [3:0]  o_byte_en,
  output logic [31:0] o_src,
  output logic        o_misalign
);

  always_comb begin
    o_byte_en = 4'b0000;
    o_src     = i_wdata;
    unique case (i_store_type)
      ST_SW: begin
        if (i_addr == 2'b00) o_byte_en = 4'b1111;
      end
      ST_SH: begin
        o_src = {2{i_wdata[15:0]}};
        if (!i_addr[0])
          o_byte_en = i_addr[1] ? 4'b1100 : 4'b0011;
      end
      ST_SB: begin
        o_src     = {4{i_wdata[7:0]}};
        o_byte_en = 4'b0001 << i_addr;
      end
      ST_RSV: begin
        o_byte_en = 4'b0000;
      end
    endcase
  end

  // Every legal store selects at least one lane.
  assign o_misalign = (o_byte_en == 4'b0000);

endmodule

// File: rtl/dm_store_merge.sv
// M-stage data memory store path: lane merge into the addressed word,
// one-edge writeback, combinational word read for the load splitter.
module dm_store_merge
  import dm_store_merge_pkg::*;
#(
  parameter int          WORD_ADDR_W = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_we,
  input  logic [1:0]  i_store_type,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic [3:0]  o_byte_en,
  output logic        o_align_err,
  output logic [15:0] o_store_cnt
);

  localparam int DEPTH = 1 << WORD_ADDR_W;

  logic [31:0]            r_mem [DEPTH];
  logic [DEPTH-1:0]       r_vld;
  logic                   r_err;
  logic [15:0]            r_cnt;

  logic [WORD_ADDR_W-1:0] w_idx;
  logic [3:0]             w_be;
  logic [31:0]            w_src;
  logic                   w_misalign;
  logic [31:0]            w_old;
  logic [31:0]            w_m32;
  logic [31:0]            w_merged;
  logic                   w_commit;

  assign w_idx = WORD_ADDR_W'((i_addr - BASE_ADDR) >> 2);

  store_lane_gen u_lane_gen (
    .i_store_type (i_store_type),
    .i_addr       (i_addr[1:0]),
    .i_wdata      (i_wdata),
    .o_byte_en    (w_be),
    .o_src        (w_src),
    .o_misalign   (w_misalign)
  );

  // Valid bits stand in for a bulk clear: an unwritten word reads as 0.
  assign w_old    = r_vld[w_idx] ? r_mem[w_idx] : 32'h0;
  assign w_m32    = lane_mask32(w_be);
  assign w_merged = (w_old & ~w_m32) | (w_src & w_m32);
  assign w_commit = i_we && !w_misalign && !i_reset;

  assign o_rdata     = w_old;
  assign o_byte_en   = i_we ? w_be : 4'b0000;
  assign o_align_err = r_err;
  assign o_store_cnt = r_cnt;

  always_ff @(posedge i_clk) begin
    if (w_commit) r_mem[w_idx] <= w_merged;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_vld <= '0;
      r_err <= 1'b0;
      r_cnt <= 16'h0;
    end else begin
      r_err <= i_we && w_misalign;
      if (w_commit) begin
        r_vld[w_idx] <= 1'b1;
        r_cnt        <= r_cnt + 16'h1;
      end
    end
  end

endmodule

// File: tb/tb_dm_store_merge.sv
// Scoreboard bench for dm_store_merge: expected words are queued at
// stimulus time and popped when the DUT read is sampled.
module tb_dm_store_merge;
  import dm_store_merge_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [1:0]  st;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [3:0]  byte_en;
  logic        align_err;
  logic [15:0] store_cnt;

  int checks   = 0;
  int failures = 0;
  logic [31:0] q_exp [$];
  logic [31:0] exp_w;
  logic [15:0] exp_cnt;

  always #5 clk = ~clk;

  dm_store_merge #(
    .WORD_ADDR_W (10),
    .BASE_ADDR   (32'h0000_0000)
  ) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_we         (we),
    .i_store_type (st),
    .i_addr       (addr),
    .i_wdata      (wdata),
    .o_rdata      (rdata),
    .o_byte_en    (byte_en),
    .o_align_err  (align_err),
    .o_store_cnt  (store_cnt)
  );

  task automatic drive(input logic w, input logic [1:0] t,
                       input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    we = w; st = t; addr = a; wdata = d;
  endtask

  task automatic idle_read(input logic [31:0] a);
    drive(1'b0, ST_SW, a, 32'h0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1; we = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 16'h0;
  endtask

  task automatic test_reset();
    drive(1'b1, ST_SW, 32'h0, 32'hDEAD_BEEF);
    exp_cnt++;
    q_exp.push_back(32'hDEAD_BEEF);
    idle_read(32'h0);
    #1;
    exp_w = q_exp.pop_front(); checks++;
    if (rdata !== exp_w) begin
      failures++;
      $display("FAIL preload rdata got=%h exp=%h", rdata, exp_w);
    end
    @(negedge clk);
    rst = 1'b1; we = 1'b1; st = ST_SW; addr = 32'h0; wdata = 32'h1234_5678;
    q_exp.push_back(32'h0);
    exp_cnt = 16'h0;
    @(negedge clk);
    rst = 1'b0; we = 1'b0;
    #1;
    exp_w = q_exp.pop_front(); checks++;
    if (rdata !== exp_w) begin
      failures++;
      $display("FAIL reset_rdata got=%h exp=%h", rdata, exp_w);
    end
    checks++;
    if (store_cnt !== exp_cnt) begin
      failures++;
      $display("FAIL reset_cnt got=%0d exp=%0d", store_cnt, exp_cnt);
    end
    checks++;
    if (align_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_err got=%b exp=0", align_err);
    end
  endtask

  task automatic test_byte_merge();
    drive(1'b1, ST_SW, 32'h4, 32'h1122_3344);
    drive(1'b1, ST_SB, 32'h6, 32'h0000_00AA);
    #1; checks++;
    if (byte_en !== 4'b0100) begin
      failures++;
      $display("FAIL sb6_byte_en got=%b exp=0100", byte_en);
    end
    q_exp.push_back(32'h11AA_3344);
    drive(1'b1, ST_SB, 32'h7, 32'h0000_00BB);
    #1;
    exp_w = q_exp.pop_front(); checks++;
    if (rdata !== exp_w) begin
      failures++;
      $display("FAIL sb6_merge got=%h exp=%h", rdata, exp_w);
    end
    checks++;
    if (byte_en !== 4'b1000) begin
      failures++;
      $display("FAIL sb7_byte_en got=%b exp=1000", byte_en);
    end
    q_exp.push_back(32'hBBAA_3344);
    idle_read(32'h4);
    #1;
    exp_w = q_exp.pop_front(); checks++;
    if (rdata !== exp_w) begin
      failures++;
      $display("FAIL sb7_accum got=%h exp=%h", rdata, exp_w);
    end
  endtask

  task automatic test_half_merge();
    pulse_reset();
    drive(1'b1, ST_SW, 32'h8, 32'h0);
    exp_cnt++;
    drive(1'b1, ST_SH, 32'hA, 32'h0000_CAFE);
    exp_cnt++;
    #1; checks++;
    if (byte_en !== 4'b1100) begin
      failures++;
      $display("FAIL shA_byte_en got=%b exp=1100", byte_en);
    end
    q_exp.push_back(32'hCAFE_0000);
    drive(1'b1, ST_SH, 32'h8, 32'h0000_1234);
    exp_cnt++;
    #1;
    exp_w = q_exp.pop_front(); checks++;
    if (rdata !== exp_w) begin
      failures++;
      $display("FAIL shA_merge got=%h exp=%h", rdata, exp_w);
    end
    q_exp.push_back(32'hCAFE_1234);
    idle_read(32'hB);
    #1;
    exp_w = q_exp.pop_front(); checks++;
    if (rdata !== exp_w) begin
      failures++;
      $display("FAIL sh8_merge got=%h exp=%h", rdata, exp_w);
    end
    checks++;
    if (store_cnt !== exp_cnt) begin
      failures++;
      $display("FAIL half_cnt got=%0d exp=%0d", store_cnt, exp_cnt);
    end
  endtask

  task automatic test_misalign();
    logic [1:0]  t [3];
    logic [31:0] a [3];
    t[0] = ST_SW;  a[0] = 32'h2;
    t[1] = ST_SH;  a[1] = 32'h1;
    t[2] = ST_RSV; a[2] = 32'h0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, t[i], a[i], 32'hFFFF_FFFF);
      #1; checks++;
      if (byte_en !== 4'b0000) begin
        failures++;
        $display("FAIL mis%0d_byte_en got=%b exp=0000", i, byte_en);
      end
      q_exp.push_back(32'h0);
      idle_read(32'h0);
      #1; checks++;
      if (align_err !== 1'b1) begin
        failures++;
        $display("FAIL mis%0d_err_set got=%b exp=1", i, align_err);
      end
      exp_w = q_exp.pop_front(); checks++;
      if (rdata !== exp_w) begin
        failures++;
        $display("FAIL mis%0d_nowrite got=%h exp=%h", i, rdata, exp_w);
      end
      checks++;
      if (store_cnt !== exp_cnt) begin
        failures++;
        $display("FAIL mis%0d_cnt got=%0d exp=%0d", i, store_cnt, exp_cnt);
      end
      idle_read(32'h0);
      #1; checks++;
      if (align_err !== 1'b0) begin
        failures++;
        $display("FAIL mis%0d_err_clr got=%b exp=0", i, align_err);
      end
    end
    drive(1'b0, ST_SW, 32'h2, 32'hFFFF_FFFF);
    idle_read(32'h0);
    #1; checks++;
    if (align_err !== 1'b0) begin
      failures++;
      $display("FAIL mis_we0_err got=%b exp=0", align_err);
    end
  endtask

  task automatic test_rdw();
    q_exp.push_back(32'h0);
    drive(1'b1, ST_SB, 32'hC, 32'h0000_00FF);
    exp_cnt++;
    #1;
    exp_w = q_exp.pop_front(); checks++;
    if (rdata !== exp_w) begin
      failures++;
      $display("FAIL rdw_old got=%h exp=%h", rdata, exp_w);
    end
    q_exp.push_back(32'h0000_00FF);
    idle_read(32'hF);
    #1;
    exp_w = q_exp.pop_front(); checks++;
    if (rdata !== exp_w) begin
      failures++;
      $display("FAIL rdw_new got=%h exp=%h", rdata, exp_w);
    end
  endtask

  task automatic test_wrap();
    drive(1'b1, ST_SW, 32'h1000, 32'h5A5A_5A5A);
    exp_cnt++;
    q_exp.push_back(32'h5A5A_5A5A);
    idle_read(32'h0);
    #1;
    exp_w = q_exp.pop_front(); checks++;
    if (rdata !== exp_w) begin
      failures++;
      $display("FAIL wrap_idx got=%h exp=%h", rdata, exp_w);
    end
    checks++;
    if (store_cnt !== exp_cnt) begin
      failures++;
      $display("FAIL wrap_cnt got=%0d exp=%0d", store_cnt, exp_cnt);
    end
  endtask

  task automatic test_cnt_wrap();
    pulse_reset();
    for (int i = 0; i < 65535; i++) begin
      drive(1'b1, ST_SB, 32'(i), 32'(i));
      exp_cnt++;
    end
    idle_read(32'h0);
    #1; checks++;
    if (store_cnt !== exp_cnt) begin
      failures++;
      $display("FAIL cnt_ffff got=%h exp=%h", store_cnt, exp_cnt);
    end
    drive(1'b1, ST_SW, 32'h0, 32'h0);
    exp_cnt++;
    idle_read(32'h0);
    #1; checks++;
    if (store_cnt !== exp_cnt) begin
      failures++;
      $display("FAIL cnt_wrap got=%h exp=%h", store_cnt, exp_cnt);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; we = 1'b0; st = ST_SW; addr = 32'h0; wdata = 32'h0;
    exp_cnt = 16'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_byte_merge();
    test_half_merge();
    test_misalign();
    test_rdw();
    test_wrap();
    test_cnt_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dm_store_merge.md
Name: dm_store_merge

Overview:
- Data memory for the M stage, covering the store path only.
- It merges sub-word store data (sb/sh) into the addressed 32-bit word lane by lane, then writes the merged word back in one clock.
- Byte lane k is word bits [8k+7:8k], little-endian. Lane 0 is [7:0], lane 3 is [31:24]. This matches the lane numbering the load-side byte splitter uses, so stored bytes read back on the same lanes.
- It also provides the combinational word read that feeds that splitter.

Parameters:
- WORD_ADDR_W, 10: word-index width; memory depth is 2**WORD_ADDR_W words.
- BASE_ADDR, 32'h0000_0000: byte address of word 0.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- we  input  1  store enable from the M-stage control.
- store_type  input  2  2'b00 = sw, 2'b01 = sh, 2'b10 = sb, 2'b11 = reserved (no write).
- addr  input  32  byte address from the ALU result in M.
- wdata  input  32  store data from rt. sb uses [7:0]; sh uses [15:0].
- rdata  output  32  combinational word at addr[WORD_ADDR_W+1:2] − BASE_ADDR index; unaffected by addr[1:0].
- byte_en  output  4  combinational lane mask the current store would write. 0 when we=0.
- align_err  output  1  registered; set for one cycle after a rejected store.
- store_cnt  output  16  registered count of committed stores; wraps 16'hFFFF→0.

Behaviour:
- Reset:
  - On a rising clk with reset=1, all words clear to 0.
  - align_err and store_cnt clear to 0.
  - The reset cycle performs no write, even if we=1.
- Word index is (addr − BASE_ADDR)[WORD_ADDR_W+1:2]. Address bits above the index are ignored, so the index wraps modulo the depth.
- Lane masks:
  - sw: 4'b1111, only when addr[1:0]=0.
  - sh: 4'b0011 when addr[1]=0; 4'b1100 when addr[1]=1; only when addr[0]=0.
  - sb: 4'b0001 << addr[1:0].
- Misalignment (sw with addr[1:0]≠0, sh with addr[0]=1) or store_type=2'b11:
  - byte_en=0 and no write.
  - align_err=1 on the next cycle only when we=1.
  - store_cnt does not increment.
- Merge:
  - Build a lane-replicated source: sb puts wdata[7:0] on all four lanes; sh puts wdata[15:0] on both halves; sw uses wdata as is.
  - merged = (old & ~mask32) | (src & mask32), where mask32 expands each byte_en bit to 8 bits.
- Timing:
  - Write latency is one edge: the merged word is visible on rdata the cycle after the store.
  - Read-during-write to the same word returns the old word in the store cycle. No bypass; the pipeline handles forwarding.
- Consecutive stores to the same word on back-to-back cycles must accumulate. Each merge reads the array value already updated by the previous edge.
- store_cnt increments by 1 per committed store (we=1, byte_en≠0, reset=0).
- align_err is 0 in every cycle that does not follow a rejected store.

Decomposition:
- Shared package / header holds:
  - store_type encodings (ST_SW, ST_SH, ST_SB).
  - lane width 8 and lane count 4.
- One natural sub-module, store_lane_gen: combinational, takes store_type, addr[1:0] and wdata; produces byte_en, the replicated src, and a misalign flag.
- The array, merge, counters and err register stay in dm_store_merge.

Test Plan:
- Reset: preload via sw 32'hDEADBEEF at 0, then assert reset for one cycle with we=1 → rdata at 0 = 0, store_cnt=0, align_err=0.
- Byte merge:
  - sw 32'h11223344 at 0x4, then sb wdata=32'h000000AA at 0x6 → rdata at 0x4 = 32'h11AA3344, byte_en=4'b0100.
  - Then sb 32'hBB at 0x7 back-to-back → 32'hBBAA3344.
- Half merge: sw 0 at 0x8, sh 32'h0000CAFE at 0xA → rdata=32'hCAFE0000; sh 32'h1234 at 0x8 → 32'hCAFE1234; store_cnt=3.
- Misalignment:
  - sw at 0x2 → no write, byte_en=0, align_err=1 for exactly one cycle, store_cnt unchanged.
  - sh at 0x1 → same response.
  - store_type=2'b11 → same response.
- Same-cycle read-during-write: sb 0xFF at 0xC over 0 → rdata=0 in the store cycle, 32'h000000FF the next cycle.
- Wrap: with WORD_ADDR_W=10, sw 32'h5A5A5A5A at 0x1000 → readable at 0x0.
  - After 65536 committed stores, store_cnt=0.
